// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access type codes, FSM states, window defaults.
// Pure declarations; no latency or flow control of its own.
package lsu_pkg;

  localparam logic [2:0] TYPE_B  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b001;
  localparam logic [2:0] TYPE_W  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b011;
  localparam logic [2:0] TYPE_HU = 3'b100;

  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

  localparam logic [31:0] DMEM_BASE_DEF  = 32'h8000_0000;
  localparam int          DMEM_BYTES_DEF = 4096;
  localparam logic [31:0] ROM_BASE_DEF   = 32'h0010_0000;
  localparam int          ROM_BYTES      = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  function automatic logic is_byte(input logic [2:0] t);
    return (t == TYPE_B) || (t == TYPE_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == TYPE_H) || (t == TYPE_HU);
  endfunction

  // 33-bit compare so a window ending at 2^32 cannot wrap
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int bytes);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 33'(bytes);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extended load value and read-modify-write merged store word.
// Combinational, zero latency, no flow control.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  typ,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte  = word[{off, 3'b000} +: 8];
    lane_half  = off[1] ? word[31:16] : word[15:0];
    load_val   = word;
    store_word = wdata;
    if (is_byte(typ)) begin
      load_val   = {{24{lane_byte[7] & (typ == TYPE_B)}}, lane_byte};
      store_word = word;
      store_word[{off, 3'b000} +: 8] = wdata[7:0];
    end else if (is_half(typ)) begin
      load_val   = {{16{lane_half[15] & (typ == TYPE_H)}}, lane_half};
      store_word = word;
      store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: one request at a time, word-only DMEM traffic, sub-word stores via read-modify-write.
// Latency load 2 / word store 2 / sub-word store 3 / error 1; req_ready low while busy, response held until rsp_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int          DMEM_BYTES = DMEM_BYTES_DEF,
  parameter logic [31:0] ROM_BASE   = ROM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  logic        op_we;
  logic [2:0]  op_type;
  logic [1:0]  op_off;
  logic [31:0] op_wdata;

  logic        misalign;
  logic        in_ram;
  logic        in_rom;
  logic        bad;
  logic        word_op;
  logic [31:0] load_val;
  logic [31:0] store_word;

  always_comb begin
    word_op  = !is_byte(req_type) && !is_half(req_type);
    misalign = is_half(req_type) ? req_addr[0] : (word_op && (req_addr[1:0] != 2'b00));
    in_ram   = in_window(req_addr, DMEM_BASE, DMEM_BYTES);
    in_rom   = in_window(req_addr, ROM_BASE, ROM_BYTES);
    // the ROM window is read-only, so stores only qualify inside RAM
    bad      = misalign || (req_we ? !in_ram : !(in_ram || in_rom));
  end

  lsu_lane u_lane (
    .off        (op_off),
    .typ        (op_type),
    .word       (mem_rdata),
    .wdata      (op_wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_type  <= 3'b000;
      op_we     <= 1'b0;
      op_type   <= 3'b000;
      op_off    <= 2'b00;
      op_wdata  <= 32'h0;
    end else begin
      mem_type <= MEM_TYPE_WORD;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_we     <= req_we;
            op_type   <= req_type;
            op_off    <= req_addr[1:0];
            op_wdata  <= req_wdata;
            if (bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else if (req_we && word_op) begin
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
              state    <= READ;
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (op_we) begin
            mem_write <= 1'b1;
            mem_wdata <= store_word;
            state     <= WRITE;
          end else begin
            mem_addr  <= 32'h0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_val;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
        end
        WRITE: begin
          mem_write <= 1'b0;
          mem_addr  <= 32'h0;
          mem_wdata <= 32'h0;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word-addressed memory model behind the DUT, scoreboard of expected responses.
// Each scenario task drives requests, pushes expectations, pops them as responses appear.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    logic [7:0]  elat;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   proto_err = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;

  logic [31:0] ram [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_dat = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8000_1000) return ram[a[11:2]];
    if (a == 32'h0010_0000) return 32'h4E55_4D42;
    if (a == 32'h0010_0004) return 32'h1672_6992;
    return 32'hDEAD_BEEF;
  endfunction

  assign mem_rdata = mem_read ? mem_peek(mem_addr) : 32'h0;

  // single writer of the memory array and the activity counters
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pre_we) ram[pre_idx] = pre_dat;
    if (mem_read) rd_cnt = rd_cnt + 1;
    if (mem_write) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = mem_addr;
      last_wd = mem_wdata;
      if (mem_addr >= 32'h8000_0000 && mem_addr < 32'h8000_1000) ram[mem_addr[11:2]] = mem_wdata;
    end
    if ((mem_read && mem_write) ||
        ((mem_read || mem_write) && (mem_addr[1:0] != 2'b00 || mem_type != 3'b010)))
      proto_err = proto_err + 1;
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] dat);
    pre_idx = addr[11:2];
    pre_dat = dat;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    int n;
    exp_q.push_back('{v.erd, v.eerr, v.elat});
    req_we = v.we; req_type = v.typ; req_addr = v.addr; req_wdata = v.wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout req_ready=%0b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic collect(output logic [31:0] rd, output logic er, output int lat, output logic got);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    got = rsp_valid; rd = rsp_rdata; er = rsp_err;
    lat = cyc - acc_cyc + 1;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 00000", {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
    end
    n_chk++; if ({rsp_rdata, mem_addr, mem_wdata, mem_type} !== 99'b0) begin
      n_fail++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h type=%b want all 0",
                         rsp_rdata, mem_addr, mem_wdata, mem_type);
    end
    rst = 1'b0;
    n_chk++; if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    n_chk++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset got %b want 1", req_ready);
    end
    n_chk++; if (mem_type !== 3'b010) begin
      n_fail++; $display("FAIL mem_type got %b want 010", mem_type);
    end
  endtask

  task automatic test_load_ext();
    vec_t tbl [9];
    logic [31:0] rd; logic er, got; int lat; exp_t e; int r0, w0;
    tbl = '{
      '{1'b0, TYPE_B,  32'h8000_0009, 32'h0, 32'hFFFF_FF80, 1'b0, 8'd2},
      '{1'b0, TYPE_BU, 32'h8000_0009, 32'h0, 32'h0000_0080, 1'b0, 8'd2},
      '{1'b0, TYPE_B,  32'h8000_0008, 32'h0, 32'hFFFF_FFF0, 1'b0, 8'd2},
      '{1'b0, TYPE_B,  32'h8000_000B, 32'h0, 32'h0000_0012, 1'b0, 8'd2},
      '{1'b0, TYPE_H,  32'h8000_0008, 32'h0, 32'hFFFF_80F0, 1'b0, 8'd2},
      '{1'b0, TYPE_HU, 32'h8000_0008, 32'h0, 32'h0000_80F0, 1'b0, 8'd2},
      '{1'b0, TYPE_H,  32'h8000_000A, 32'h0, 32'h0000_1234, 1'b0, 8'd2},
      '{1'b0, TYPE_W,  32'h8000_0008, 32'h0, 32'h1234_80F0, 1'b0, 8'd2},
      '{1'b0, 3'b111,  32'h8000_0008, 32'h0, 32'h1234_80F0, 1'b0, 8'd2}
    };
    preload(32'h8000_0008, 32'h1234_80F0);
    r0 = rd_cnt; w0 = wr_cnt;
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i]);
      collect(rd, er, lat, got);
      e = exp_q.pop_front();
      n_chk++; if (!got || rd !== e.rdata) begin n_fail++; $display("FAIL load[%0d] rdata got %h (valid %0b) want %h", i, rd, got, e.rdata); end
      n_chk++; if (er !== e.err) begin n_fail++; $display("FAIL load[%0d] err got %b want %b", i, er, e.err); end
      n_chk++; if (lat != int'(e.lat)) begin n_fail++; $display("FAIL load[%0d] latency got %0d want %0d", i, lat, e.lat); end
    end
    n_chk++; if (rd_cnt - r0 != 9 || wr_cnt != w0) begin
      n_fail++; $display("FAIL load_mem_traffic reads %0d writes %0d want 9 and 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_sub_store();
    vec_t tbl [6];
    logic [31:0] ewr [6];
    logic [31:0] rd; logic er, got; int lat; exp_t e; int w0;
    tbl = '{
      '{1'b1, TYPE_B, 32'h8000_000A, 32'hFFFF_FFAB, 32'h0,         1'b0, 8'd3},
      '{1'b0, TYPE_W, 32'h8000_0008, 32'h0,         32'h12AB_80F0, 1'b0, 8'd2},
      '{1'b1, TYPE_H, 32'h8000_0012, 32'h5555_BEEF, 32'h0,         1'b0, 8'd3},
      '{1'b0, TYPE_W, 32'h8000_0010, 32'h0,         32'hBEEF_2222, 1'b0, 8'd2},
      '{1'b1, TYPE_W, 32'h8000_0FFC, 32'hA5A5_5A5A, 32'h0,         1'b0, 8'd2},
      '{1'b0, TYPE_W, 32'h8000_0FFC, 32'h0,         32'hA5A5_5A5A, 1'b0, 8'd2}
    };
    ewr = '{32'h12AB_80F0, 32'h0, 32'hBEEF_2222, 32'h0, 32'hA5A5_5A5A, 32'h0};
    preload(32'h8000_0008, 32'h1234_80F0);
    preload(32'h8000_0010, 32'h1111_2222);
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt;
      issue(tbl[i]);
      collect(rd, er, lat, got);
      e = exp_q.pop_front();
      n_chk++; if (!got || rd !== e.rdata) begin n_fail++; $display("FAIL store[%0d] rdata got %h (valid %0b) want %h", i, rd, got, e.rdata); end
      n_chk++; if (er !== e.err) begin n_fail++; $display("FAIL store[%0d] err got %b want %b", i, er, e.err); end
      n_chk++; if (lat != int'(e.lat)) begin n_fail++; $display("FAIL store[%0d] latency got %0d want %0d", i, lat, e.lat); end
      if (tbl[i].we) begin
        n_chk++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL store[%0d] write_cycles got %0d want 1", i, wr_cnt - w0); end
        n_chk++; if (last_wd !== ewr[i] || last_wa !== {tbl[i].addr[31:2], 2'b00}) begin
          n_fail++; $display("FAIL store[%0d] write got %h@%h want %h@%h", i, last_wd, last_wa, ewr[i], {tbl[i].addr[31:2], 2'b00});
        end
      end
    end
  endtask

  task automatic test_windows();
    vec_t tbl [11];
    logic [31:0] rd; logic er, got; int lat; exp_t e; int r0, w0;
    tbl = '{
      '{1'b0, TYPE_W,  32'h0010_0004, 32'h0, 32'h1672_6992, 1'b0, 8'd2},
      '{1'b0, TYPE_B,  32'h0010_0007, 32'h0, 32'h0000_0016, 1'b0, 8'd2},
      '{1'b0, TYPE_W,  32'h0010_0000, 32'h0, 32'h4E55_4D42, 1'b0, 8'd2},
      '{1'b0, TYPE_BU, 32'h8000_0FFF, 32'h0, 32'h0000_00A5, 1'b0, 8'd2},
      '{1'b1, TYPE_W,  32'h0010_0000, 32'h1, 32'h0,         1'b1, 8'd1},
      '{1'b1, TYPE_B,  32'h0010_0001, 32'h1, 32'h0,         1'b1, 8'd1},
      '{1'b0, TYPE_H,  32'h8000_0003, 32'h0, 32'h0,         1'b1, 8'd1},
      '{1'b1, TYPE_W,  32'h8000_0002, 32'h7, 32'h0,         1'b1, 8'd1},
      '{1'b0, TYPE_W,  32'h8000_1000, 32'h0, 32'h0,         1'b1, 8'd1},
      '{1'b0, TYPE_W,  32'h7FFF_FFFC, 32'h0, 32'h0,         1'b1, 8'd1},
      '{1'b0, TYPE_B,  32'h0010_0008, 32'h0, 32'h0,         1'b1, 8'd1}
    };
    r0 = rd_cnt; w0 = wr_cnt;
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i]);
      collect(rd, er, lat, got);
      e = exp_q.pop_front();
      n_chk++; if (!got || rd !== e.rdata) begin n_fail++; $display("FAIL window[%0d] rdata got %h (valid %0b) want %h", i, rd, got, e.rdata); end
      n_chk++; if (er !== e.err) begin n_fail++; $display("FAIL window[%0d] err got %b want %b", i, er, e.err); end
      n_chk++; if (lat != int'(e.lat)) begin n_fail++; $display("FAIL window[%0d] latency got %0d want %0d", i, lat, e.lat); end
    end
    n_chk++; if (rd_cnt - r0 != 4 || wr_cnt != w0) begin
      n_fail++; $display("FAIL window_mem_traffic reads %0d writes %0d want 4 and 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, got; int lat; exp_t e; int prev;
    logic [31:0] vals [3];
    vals = '{32'h0102_0304, 32'hF0E0_D0C0, 32'h7777_0001};
    for (int i = 0; i < 3; i++) preload(32'h8000_0040 + 32'(4 * i), vals[i]);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      issue('{1'b0, TYPE_W, 32'h8000_0040 + 32'(4 * i), 32'h0, vals[i], 1'b0, 8'd2});
      if (i > 0) begin
        n_chk++; if (acc_cyc - prev != 3) begin n_fail++; $display("FAIL b2b[%0d] spacing got %0d want 3", i, acc_cyc - prev); end
      end
      prev = acc_cyc;
      collect(rd, er, lat, got);
      e = exp_q.pop_front();
      n_chk++; if (!got || rd !== e.rdata || er !== e.err) begin
        n_fail++; $display("FAIL b2b[%0d] rsp got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e; int n;
    preload(32'h8000_0020, 32'h0000_00C3);
    rsp_ready = 1'b0;
    issue('{1'b0, TYPE_B, 32'h8000_0020, 32'h0, 32'hFFFF_FFC3, 1'b0, 8'd2});
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata) begin
        n_fail++; $display("FAIL hold[%0d] valid/rdata got %b/%h want 1/%h", i, rsp_valid, rsp_rdata, e.rdata);
      end
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] req_ready got %b want 0", i, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release valid/ready got %b/%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_write();
    int n, w0;
    preload(32'h8000_0024, 32'hCAFE_F00D);
    w0 = wr_cnt;
    issue('{1'b1, TYPE_H, 32'h8000_0026, 32'h0000_1234, 32'h0, 1'b0, 8'd3});
    n = 0;
    while (!mem_write && n < 20) begin @(posedge clk); #1; n++; end
    n_chk++; if (mem_write !== 1'b1 || mem_wdata !== 32'h1234_F00D) begin
      n_fail++; $display("FAIL rmw_merge write/wdata got %b/%h want 1/1234f00d", mem_write, mem_wdata);
    end
    rst = 1'b1;
    #1;
    n_chk++; if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write, rsp_rdata, mem_addr, mem_wdata, mem_type} !== 104'b0) begin
      n_fail++; $display("FAIL reset_in_write outputs not all 0 (write %b wdata %h addr %h)", mem_write, mem_wdata, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_chk++; if (ram[9] !== 32'hCAFE_F00D || wr_cnt != w0) begin
      n_fail++; $display("FAIL reset_no_commit word got %h writes %0d want cafef00d and 0", ram[9], wr_cnt - w0);
    end
    // a pending error response is dropped by reset
    rsp_ready = 1'b0;
    issue('{1'b0, TYPE_W, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 8'd1});
    n_chk++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_before_reset valid/err got %b/%b want 1/1", rsp_valid, rsp_err);
    end
    rst = 1'b1;
    #1;
    n_chk++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_resp valid/err got %b/%b want 0/0", rsp_valid, rsp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_ext();
    test_sub_store();
    test_windows();
    test_back_to_back();
    test_hold();
    test_reset_write();
    n_chk++; if (proto_err != 0) begin
      n_fail++; $display("FAIL mem_protocol violations got %0d want 0", proto_err);
    end
    n_chk++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard leftover got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the execute stage and the word-addressed data memory (`DMEM`). It accepts one load or store request per transaction and checks alignment and address window. Loads extract the addressed byte or halfword lane with sign or zero extension. Sub-word stores use a read-modify-write, so only the addressed byte or halfword lanes change in the stored word. All memory traffic is issued as full 32-bit word accesses (`data_type` = 3'b010).

## Interface
Parameters:
- `DMEM_BASE`, 32'h8000_0000: start of the data RAM window (byte address).
- `DMEM_BYTES`, 4096: size of the RAM window in bytes.
- `ROM_BASE`, 32'h0010_0000: start of the read-only N-number window, 8 bytes.

Ports:
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LBU, 100 LHU; any other code is treated as a word access.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load result (0 for stores and errors).
- `rsp_err` out 1: misaligned access or access outside a window.
- `mem_read` out 1: to DMEM `memread`.
- `mem_write` out 1: to DMEM `memwrite`.
- `mem_addr` out 32: word-aligned address (low 2 bits = 0).
- `mem_wdata` out 32: merged full word.
- `mem_type` out 3: constant 3'b010.
- `mem_rdata` in 32: DMEM `out_data`; combinational, valid in the same cycle `mem_read` is high.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, type, addr and wdata, then classify the request.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0) → RESP with err=1.
  - Load outside both windows → RESP with err=1.
  - Store outside the RAM window, including any store to the ROM window → RESP with err=1.
  - Word store → WRITE.
  - Load or sub-word store → READ.
- READ:
  - `mem_read`=1, `mem_addr`={addr[31:2],2'b00}; capture `mem_rdata` at the edge.
  - Load: extract lane by addr[1:0] (byte lane k = bits 8k+7:8k; half lane = bits 31:16 if addr[1], else 15:0), extend according to type, → RESP.
  - Sub-word store: merge the wdata byte/half into the captured word at that lane, → WRITE.
- WRITE: `mem_write`=1 with the merged (or full) word for exactly one cycle → RESP.
- RESP: `rsp_valid`=1 and hold `rsp_rdata`/`rsp_err` stable until `rsp_ready`, then → IDLE.
- `mem_read` and `mem_write` are never high together, and both are 0 outside READ/WRITE.
- No request is accepted while busy; `req_ready`=0 in READ/WRITE/RESP.

## Timing
- Reset value of every output is 0, including `req_ready`; state is IDLE. `req_ready` rises in the first cycle after `rst` deasserts.
- Latency, counted as edges from the accept edge to the first `rsp_valid` cycle:
  - Load: 2 (READ, then RESP).
  - Word store: 2 (WRITE, then RESP).
  - Sub-word store: 3 (READ, WRITE, then RESP).
  - Error: 1.
- A response accepted with `rsp_ready` in the first RESP cycle returns to IDLE; back-to-back loads run at 1 per 3 cycles.
- Reset asserted in WRITE before the edge: no write is committed and state is forced to IDLE asynchronously. Reset in RESP drops the response.
- Window checks use the full 32-bit address. The last valid RAM word is `DMEM_BASE`+`DMEM_BYTES`-4; `DMEM_BASE`+`DMEM_BYTES` is an error.

## Structure
- Package `lsu_pkg` holds:
  - the type codes (TYPE_B, TYPE_H, TYPE_W, TYPE_BU, TYPE_HU);
  - the state enum;
  - the window base/size constants.
- Sub-module `lsu_lane` (combinational) takes addr[1:0], type, mem word and wdata. It produces the extended load value and the merged store word, and is reused for both READ outcomes.
- The FSM and the request/response registers live in `lsu_ctrl`.

## Test plan
- Preload RAM word 0x8000_0008 with 32'h1234_80F0; LB at 0x8000_0009 → rsp_rdata 32'hFFFF_FF80. LBU at the same address → 32'h0000_0080.
- SB 0xAB to 0x8000_000A over word 32'h1234_80F0 → one `mem_write` cycle with `mem_wdata`=32'h12AB_80F0; a following LW at 0x8000_0008 returns 32'h12AB_80F0.
- LW at 0x0010_0004 → 32'h1672_6992. SW to 0x0010_0000 → rsp_err=1 with `mem_write` never asserted.
- LH at 0x8000_0003 and SW at 0x8000_0002 → rsp_err=1 after 1 cycle with no `mem_read`/`mem_write`; LW at 0x8000_1000 → rsp_err=1.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_rdata` stay stable and `req_ready` stays 0. Asserting `rst` during WRITE of an SH → memory word unchanged, all outputs 0.
